// File: rtl/midi_gate.sv
// MIDI byte parser and last-note-priority held-note stack producing gate, note,
// velocity and retrigger controls for the envelope and oscillators.
module midi_gate #(
   parameter int CHANNEL = 0,
   parameter int DEPTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_byte,
   input  logic       in_valid,
   output logic       gate,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic       retrig,
   output logic [4:0] stack_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA1 = 2'd1;
   localparam logic [1:0] S_DATA2 = 2'd2;

   localparam logic [3:0] CH      = 4'(CHANNEL);
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   logic [1:0] state;
   logic [7:0] status;
   logic [6:0] d1;
   logic [6:0] stk [DEPTH];
   logic [4:0] count;

   logic is_sys, is_status, is_data, exec;
   logic do_on, do_off, do_clr;

   logic       found;
   logic [4:0] idx;
   logic [4:0] rm_cnt, psh_cnt, nxt_cnt;
   logic [6:0] rm_stk  [DEPTH];
   logic [6:0] psh_stk [DEPTH];
   logic [6:0] nxt_stk [DEPTH];
   logic [6:0] nxt_top;

   function automatic logic on_chan(input logic [7:0] st, input logic [3:0] kind);
      return (st[7:4] == kind) && (st[3:0] == CH);
   endfunction

   // Byte classification; real-time bytes (0xF8-0xFF) match none of these.
   assign is_sys    = in_valid && (in_byte[7:4] == 4'hF) && !in_byte[3];
   assign is_status = in_valid && in_byte[7] && (in_byte[7:4] != 4'hF);
   assign is_data   = in_valid && !in_byte[7];
   assign exec      = is_data && (state == S_DATA2);

   assign do_on  = exec && on_chan(status, 4'h9) && (in_byte[6:0] != 7'd0);
   assign do_off = exec && ((on_chan(status, 4'h9) && (in_byte[6:0] == 7'd0))
                            || on_chan(status, 4'h8));
   assign do_clr = exec && on_chan(status, 4'hB) && (d1 == 7'h7B);

   // Single-cycle stack update: remove d1 if present, then optionally push it.
   always_comb begin
      found = 1'b0;
      idx   = 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && (5'(i) < count) && (stk[i] == d1)) begin
            found = 1'b1;
            idx   = 5'(i);
         end
      end
      rm_cnt = count - {4'd0, found};

      for (int i = 0; i < DEPTH - 1; i++) begin
         rm_stk[i] = (found && (5'(i) >= idx)) ? stk[i+1] : stk[i];
      end
      rm_stk[DEPTH-1] = stk[DEPTH-1];

      psh_stk = rm_stk;
      if (rm_cnt == DEPTH_C) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            psh_stk[i] = rm_stk[i+1];
         end
         psh_stk[DEPTH-1] = d1;
         psh_cnt          = DEPTH_C;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (5'(i) == rm_cnt) psh_stk[i] = d1;
         end
         psh_cnt = rm_cnt + 5'd1;
      end

      nxt_stk = stk;
      nxt_cnt = count;
      if (do_on) begin
         nxt_stk = psh_stk;
         nxt_cnt = psh_cnt;
      end else if (do_off) begin
         nxt_stk = rm_stk;
         nxt_cnt = rm_cnt;
      end else if (do_clr) begin
         nxt_cnt = 5'd0;
      end

      // An empty stack keeps the previous pitch for the release stage.
      nxt_top = note;
      for (int i = 0; i < DEPTH; i++) begin
         if ((nxt_cnt != 5'd0) && (5'(i) == nxt_cnt - 5'd1)) nxt_top = nxt_stk[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         status   <= 8'd0;
         count    <= 5'd0;
         gate     <= 1'b0;
         note     <= 7'd0;
         velocity <= 7'd0;
         retrig   <= 1'b0;
      end else begin
         retrig <= do_on;
         if (is_sys) begin
            status <= 8'd0;
            state  <= S_IDLE;
         end else if (is_status) begin
            status <= in_byte;
            state  <= S_DATA1;
         end else if (is_data) begin
            case (state)
               S_DATA1: state <= S_DATA2;
               S_DATA2: state <= S_DATA1;
               S_IDLE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
         count <= nxt_cnt;
         gate  <= (nxt_cnt != 5'd0);
         note  <= nxt_top;
         if (do_on) velocity <= in_byte[6:0];
      end
   end

   // Stack entries and the first data byte are qualified by count/state, so no reset.
   always_ff @(posedge clk) begin
      stk <= nxt_stk;
      if (is_data && (state == S_DATA1)) d1 <= in_byte[6:0];
   end

   assign stack_count = count;

endmodule

// File: tb/tb_midi_gate.sv
// Directed bench for midi_gate: driver queues expected output snapshots, a
// negedge monitor pops and compares them on the cycle they are due.
module tb_midi_gate;

   logic       clk;
   logic       rst;
   logic [7:0] in_byte;
   logic       in_valid;
   logic       gate;
   logic [6:0] note;
   logic [6:0] velocity;
   logic       retrig;
   logic [4:0] stack_count;

   midi_gate #(.CHANNEL(0), .DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_byte    (in_byte),
      .in_valid   (in_valid),
      .gate       (gate),
      .note       (note),
      .velocity   (velocity),
      .retrig     (retrig),
      .stack_count(stack_count)
   );

   typedef struct {
      int         due;
      logic       g;
      logic [6:0] n;
      logic [6:0] v;
      logic       r;
      logic [4:0] c;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   cyc;
   int   checks;
   int   errors;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s cyc %0d got %0h want %0h", name, cyc, act, want);
      end
   endtask

   task automatic push_cur(input logic r);
      exp_t e;
      e     = cur;
      e.r   = r;
      e.due = cyc + 1;
      q.push_back(e);
   endtask

   // Send a byte that changes the expected outputs.
   task automatic xb(input logic [7:0] b, input logic g, input logic [6:0] n,
                     input logic [6:0] v, input logic r, input logic [4:0] c);
      @(posedge clk);
      #1;
      in_byte  = b;
      in_valid = 1'b1;
      cur.g = g;
      cur.n = n;
      cur.v = v;
      cur.c = c;
      push_cur(r);
   endtask

   // Send a byte that leaves the outputs unchanged.
   task automatic sb(input logic [7:0] b);
      @(posedge clk);
      #1;
      in_byte  = b;
      in_valid = 1'b1;
      push_cur(1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_byte  = 8'h00;
         push_cur(1'b0);
      end
   endtask

   task automatic check_now(input string tag);
      cmp({tag, "_gate"}, int'(gate), int'(cur.g));
      cmp({tag, "_note"}, int'(note), int'(cur.n));
      cmp({tag, "_vel"}, int'(velocity), int'(cur.v));
      cmp({tag, "_retrig"}, int'(retrig), 0);
      cmp({tag, "_count"}, int'(stack_count), int'(cur.c));
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
               cmp("late_entry", cyc, e.due);
            end else begin
               cmp("gate", int'(gate), int'(e.g));
               cmp("note", int'(note), int'(e.n));
               cmp("velocity", int'(velocity), int'(e.v));
               cmp("retrig", int'(retrig), int'(e.r));
               cmp("stack_count", int'(stack_count), int'(e.c));
            end
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      cur      = '{due: 0, g: 1'b0, n: 7'd0, v: 7'd0, r: 1'b0, c: 5'd0};
      #12;
      check_now("reset");
      #5;
      rst = 1'b1;

      // Note-on, running-status second note, note-off of the top note.
      sb(8'h90); sb(8'h3C); xb(8'h64, 1'b1, 7'h3C, 7'h64, 1'b1, 5'd1);
      sb(8'h40); xb(8'h50, 1'b1, 7'h40, 7'h50, 1'b1, 5'd2);
      sb(8'h80); sb(8'h40); xb(8'h00, 1'b1, 7'h3C, 7'h50, 1'b0, 5'd1);
      // Velocity-0 note-off empties the stack; note holds its pitch.
      sb(8'h90); sb(8'h3C); xb(8'h00, 1'b0, 7'h3C, 7'h50, 1'b0, 5'd0);
      // Other channel ignored.
      sb(8'h91); sb(8'h30); sb(8'h7F);
      idle(1);

      // Overflow: notes 1..9 into an 8-deep stack.
      sb(8'h90);
      for (int k = 1; k <= 9; k++) begin
         sb(8'(k));
         xb(8'h20, 1'b1, 7'(k), 7'h20, 1'b1, (k > 8) ? 5'd8 : 5'(k));
      end
      sb(8'h80);
      for (int k = 9; k >= 2; k--) begin
         sb(8'(k));
         xb(8'h00, (k > 2), (k > 2) ? 7'(k - 1) : 7'd2, 7'h20, 1'b0, 5'(k - 2));
      end
      // Note 1 was discarded on overflow.
      sb(8'h01); sb(8'h00);
      idle(1);

      // Real-time byte mid-message is transparent.
      sb(8'h90); sb(8'h3C); sb(8'hF8); xb(8'h64, 1'b1, 7'h3C, 7'h64, 1'b1, 5'd1);
      // System common abandons the message and clears running status.
      sb(8'h90); sb(8'h3C); sb(8'hF0); sb(8'h64);
      idle(1);

      // Re-pressing a held note moves it to the top.
      sb(8'h90); sb(8'h40); xb(8'h11, 1'b1, 7'h40, 7'h11, 1'b1, 5'd2);
      sb(8'h3C); xb(8'h12, 1'b1, 7'h3C, 7'h12, 1'b1, 5'd2);
      sb(8'h40); xb(8'h00, 1'b1, 7'h3C, 7'h12, 1'b0, 5'd1);

      // Three held notes, unrelated controller, then all-notes-off.
      sb(8'h45); xb(8'h42, 1'b1, 7'h45, 7'h42, 1'b1, 5'd2);
      sb(8'h47); xb(8'h43, 1'b1, 7'h47, 7'h43, 1'b1, 5'd3);
      sb(8'hB0); sb(8'h07); sb(8'h10);
      sb(8'h7B); xb(8'h00, 1'b0, 7'h47, 7'h43, 1'b0, 5'd0);
      idle(1);

      // Asynchronous reset in the middle of a message.
      sb(8'h90); sb(8'h3C); xb(8'h7F, 1'b1, 7'h3C, 7'h7F, 1'b1, 5'd1);
      sb(8'h3C);
      idle(2);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #2;
      rst = 1'b0;
      cur = '{due: 0, g: 1'b0, n: 7'd0, v: 7'd0, r: 1'b0, c: 5'd0};
      #1;
      check_now("async_rst");
      @(posedge clk);
      #2;
      rst = 1'b1;
      // Data bytes after reset have no running status.
      sb(8'h40); sb(8'h22);
      idle(2);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      #2;
      if (q.size() != 0) cmp("queue_drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
